wb_initiator_fsm: RTL and testbench

//  Single-outstanding Wishbone initiator: takes a command over a valid/ready port, runs one

---
 rtl/wb_initiator_fsm.sv | 148 ++++++++++++++
 tb/tb_wb_initiator_fsm.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_initiator_fsm.sv
// ---------------------------------------------------------------------------
// wb_initiator_fsm
//   Single-outstanding Wishbone initiator. A command arrives over a
//   valid/ready port, one Wishbone cycle is run on the WBs_* bus, and the
//   read data plus an ACK-timeout flag come back over a valid/ready
//   response port. Only one transaction is ever in flight.
//
// Ports
//   WB_CLK, WB_RST_n     clock, synchronous active-low reset
//   Cmd_*                command channel (valid/ready, WE, Addr, BE, WDat)
//   Rsp_*                response channel (valid/ready, RDat, Err)
//   WBs_* outputs        registered Wishbone request signals
//   WBs_RD_DAT_i/ACK_i   responder read data and acknowledge
// ---------------------------------------------------------------------------
module wb_initiator_fsm #(
  parameter int ADDRWIDTH = 17,
  parameter int DATAWIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 WB_CLK,
  input  logic                 WB_RST_n,
  input  logic                 Cmd_Valid_i,
  output logic                 Cmd_Ready_o,
  input  logic                 Cmd_WE_i,
  input  logic [ADDRWIDTH-1:0] Cmd_Addr_i,
  input  logic [3:0]           Cmd_BE_i,
  input  logic [DATAWIDTH-1:0] Cmd_WDat_i,
  output logic                 Rsp_Valid_o,
  input  logic                 Rsp_Ready_i,
  output logic [DATAWIDTH-1:0] Rsp_RDat_o,
  output logic                 Rsp_Err_o,
  output logic [ADDRWIDTH-1:0] WBs_ADR_o,
  output logic                 WBs_CYC_o,
  output logic                 WBs_STB_o,
  output logic                 WBs_WE_o,
  output logic                 WBs_RD_o,
  output logic [3:0]           WBs_BYTE_STB_o,
  output logic [DATAWIDTH-1:0] WBs_WR_DAT_o,
  input  logic [DATAWIDTH-1:0] WBs_RD_DAT_i,
  input  logic                 WBs_ACK_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Counter value seen on the last bus cycle before the abort.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]           state_reg, state_next;
  logic [15:0]          cnt_reg;
  logic [ADDRWIDTH-1:0] adr_reg;
  logic                 cyc_reg;
  logic                 stb_reg;
  logic                 we_reg;
  logic                 rd_reg;
  logic [3:0]           be_reg;
  logic [DATAWIDTH-1:0] wdat_reg;
  logic                 rsp_valid_reg;
  logic [DATAWIDTH-1:0] rdat_reg;
  logic                 err_reg;

  logic                 bus_done;
  logic                 timed_out;

  // ACK wins over timeout when both happen on the same cycle.
  assign timed_out = (cnt_reg == CNT_LAST) && !WBs_ACK_i;
  assign bus_done  = WBs_ACK_i || (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (Cmd_Valid_i) state_next = ST_BUS;
      ST_BUS:  if (bus_done)    state_next = ST_RESP;
      ST_RESP: if (Rsp_Ready_i) state_next = ST_IDLE;
      default:                  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge WB_CLK) begin
    if (!WB_RST_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      adr_reg       <= '0;
      cyc_reg       <= 1'b0;
      stb_reg       <= 1'b0;
      we_reg        <= 1'b0;
      rd_reg        <= 1'b0;
      be_reg        <= '0;
      wdat_reg      <= '0;
      rsp_valid_reg <= 1'b0;
      rdat_reg      <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          // The bus request is launched straight from the handshake so the
          // first bus cycle is the clock right after acceptance.
          if (Cmd_Valid_i) begin
            adr_reg  <= Cmd_Addr_i;
            we_reg   <= Cmd_WE_i;
            rd_reg   <= ~Cmd_WE_i;
            be_reg   <= Cmd_BE_i;
            wdat_reg <= Cmd_WDat_i;
            cyc_reg  <= 1'b1;
            stb_reg  <= 1'b1;
            cnt_reg  <= '0;
          end
        end
        ST_BUS: begin
          cnt_reg <= cnt_reg + 16'd1;
          if (bus_done) begin
            // ADR and WR_DAT are left as they are; responders qualify on CYC&STB.
            cyc_reg       <= 1'b0;
            stb_reg       <= 1'b0;
            we_reg        <= 1'b0;
            rd_reg        <= 1'b0;
            be_reg        <= '0;
            rsp_valid_reg <= 1'b1;
            err_reg       <= timed_out;
            rdat_reg      <= (WBs_ACK_i && !we_reg) ? WBs_RD_DAT_i : '0;
          end
        end
        ST_RESP: begin
          if (Rsp_Ready_i) begin
            rsp_valid_reg <= 1'b0;
            cnt_reg       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign Cmd_Ready_o    = (state_reg == ST_IDLE);
  assign Rsp_Valid_o    = rsp_valid_reg;
  assign Rsp_RDat_o     = rdat_reg;
  assign Rsp_Err_o      = err_reg;
  assign WBs_ADR_o      = adr_reg;
  assign WBs_CYC_o      = cyc_reg;
  assign WBs_STB_o      = stb_reg;
  assign WBs_WE_o       = we_reg;
  assign WBs_RD_o       = rd_reg;
  assign WBs_BYTE_STB_o = be_reg;
  assign WBs_WR_DAT_o   = wdat_reg;

endmodule

// File: tb/tb_wb_initiator_fsm.sv
// ---------------------------------------------------------------------------
// tb_wb_initiator_fsm
//   Directed + randomised bench for wb_initiator_fsm (TIMEOUT=8).
//   A negedge responder model answers bus cycles with a programmable ACK
//   delay from its own memory; expected responses are queued when commands
//   are issued and popped when the response is consumed.
// ---------------------------------------------------------------------------
module tb_wb_initiator_fsm;

  localparam int AW = 17;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [3:0]    cmd_be;
  logic [DW-1:0] cmd_wdat;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdat;
  logic [AW-1:0] wb_adr;
  logic          wb_cyc, wb_stb, wb_we, wb_rd, wb_ack;
  logic [3:0]    wb_be;
  logic [DW-1:0] wb_wdat, wb_rdat;

  always #5 clk = ~clk;

  wb_initiator_fsm #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT(8)) dut (
    .WB_CLK(clk), .WB_RST_n(rst_n),
    .Cmd_Valid_i(cmd_valid), .Cmd_Ready_o(cmd_ready), .Cmd_WE_i(cmd_we),
    .Cmd_Addr_i(cmd_addr), .Cmd_BE_i(cmd_be), .Cmd_WDat_i(cmd_wdat),
    .Rsp_Valid_o(rsp_valid), .Rsp_Ready_i(rsp_ready),
    .Rsp_RDat_o(rsp_rdat), .Rsp_Err_o(rsp_err),
    .WBs_ADR_o(wb_adr), .WBs_CYC_o(wb_cyc), .WBs_STB_o(wb_stb),
    .WBs_WE_o(wb_we), .WBs_RD_o(wb_rd), .WBs_BYTE_STB_o(wb_be),
    .WBs_WR_DAT_o(wb_wdat), .WBs_RD_DAT_i(wb_rdat), .WBs_ACK_i(wb_ack)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [DW-1:0] rdat;
    logic          err;
  } rsp_t;
  rsp_t exp_q[$];

  logic [DW-1:0] resp_mem [16];   // responder storage
  logic [DW-1:0] ref_mem  [16];   // expected storage
  int ack_delay = 0;
  bit ack_off   = 1'b0;
  int bus_cnt   = 0;

  // Responder: ACK after ack_delay wait states, junk data when not acking.
  always @(negedge clk) begin
    if (wb_cyc && wb_stb) begin
      if (!ack_off && bus_cnt == ack_delay) begin
        wb_ack = 1'b1;
        if (wb_we) begin
          for (int b = 0; b < 4; b++)
            if (wb_be[b]) resp_mem[wb_adr[3:0]][8*b +: 8] = wb_wdat[8*b +: 8];
          wb_rdat = 32'hFFFF_FFFF;
        end else begin
          wb_rdat = resp_mem[wb_adr[3:0]];
        end
      end else begin
        wb_ack  = 1'b0;
        wb_rdat = 32'hDEAD_BEEF;
      end
      bus_cnt++;
    end else begin
      wb_ack  = 1'b0;
      wb_rdat = 32'hDEAD_BEEF;
      bus_cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command, follow the bus cycle, check its shape and the latency
  // to Rsp_Valid. Returns at the negedge where Rsp_Valid is first seen.
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [3:0] be,
                       input logic [DW-1:0] wdat, input int delay, input bit never,
                       input int exp_cyc);
    int   cyc_clks;
    int   lat;
    int   w;
    rsp_t e;
    ack_delay = delay;
    ack_off   = never;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_be = be; cmd_wdat = wdat;
    w = 0;
    while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
    chk("cmd_ready_wait", cmd_ready, 1'b1);
    // expected response from the reference memory
    if (never) e = '{rdat: '0, err: 1'b1};
    else if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[addr[3:0]][8*b +: 8] = wdat[8*b +: 8];
      e = '{rdat: '0, err: 1'b0};
    end else e = '{rdat: ref_mem[addr[3:0]], err: 1'b0};
    exp_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("first_cyc", {wb_cyc, wb_stb, wb_we, wb_rd}, {1'b1, 1'b1, we, ~we});
    chk("first_adr", wb_adr, addr);
    chk("first_be_wdat", {wb_be, wb_wdat}, {be, wdat});
    chk("cmd_ready_busy", cmd_ready, 1'b0);
    lat = 1; cyc_clks = 0;
    while (!rsp_valid && lat < 40) begin
      if (wb_cyc) cyc_clks++;
      @(negedge clk);
      lat++;
    end
    chk("rsp_seen", rsp_valid, 1'b1);
    chk("cyc_clks", cyc_clks, exp_cyc);
    chk("latency", lat, exp_cyc + 1);
    chk("teardown", {wb_cyc, wb_stb, wb_we, wb_rd, wb_be}, 8'h00);
    chk("adr_kept", wb_adr, addr);
  endtask

  // Hold Rsp_Ready low for 'hold' cycles, then consume and check.
  task automatic consume(input int hold);
    rsp_t e;
    if (exp_q.size() == 0) begin
      chk("queue_nonempty", 64'(exp_q.size()), 64'd1);
      return;
    end
    e = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      chk("hold_rsp", {rsp_valid, rsp_err, rsp_rdat}, {1'b1, e.err, e.rdat});
      chk("hold_idle", {cmd_ready, wb_cyc}, 2'b00);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    chk("rsp_rdat", rsp_rdat, e.rdat);
    chk("rsp_err", rsp_err, e.err);
    $display("rsp: rdat=0x%08h err=%0d (expected 0x%08h/%0d)", rsp_rdat, rsp_err, e.rdat, e.err);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_consume", {rsp_valid, cmd_ready, wb_cyc}, 3'b010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          r_we;
    logic [AW-1:0] r_addr;
    for (int i = 0; i < 16; i++) begin
      resp_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      ref_mem[i]  = resp_mem[i];
    end
    resp_mem[15] = 32'h1234_5678;
    ref_mem[15]  = 32'h1234_5678;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_be = '0;
    cmd_wdat = '0; rsp_ready = 1'b0; wb_ack = 1'b0; wb_rdat = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_bus", {wb_cyc, wb_stb, wb_we, wb_rd, wb_be}, 8'h00);
    chk("reset_adr_wdat", {wb_adr, wb_wdat}, '0);
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_rdat}, '0);
    chk("reset_ready", cmd_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: write with two wait states -> CYC for 3 clocks
    issue(1'b1, 17'h00010, 4'hF, 32'hA5A5_5A5A, 2, 1'b0, 3);
    consume(0);
    chk("write_landed", resp_mem[0], 32'hA5A5_5A5A);

    // 2: read with immediate ACK -> response 2 clocks after handshake
    issue(1'b0, 17'h1FFFF, 4'hF, 32'h0, 0, 1'b0, 1);
    consume(0);

    // 3: no ACK -> timeout after 8 bus clocks
    issue(1'b0, 17'h00003, 4'hF, 32'h0, 0, 1'b1, 8);
    consume(0);

    // 4: response back-pressure with a new command waiting
    issue(1'b0, 17'h00005, 4'hF, 32'h0, 1, 1'b0, 2);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 17'h00007; cmd_wdat = 32'h0BAD_F00D;
    consume(5);
    cmd_valid = 1'b0;
    chk("no_accept", resp_mem[7], ref_mem[7]);

    // 5: reset during the second of four bus cycles
    ack_delay = 3; ack_off = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 17'h00009; cmd_be = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst_bus_active", wb_cyc, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midbus_rst_bus", {wb_cyc, wb_stb, wb_we, wb_rd, wb_be}, 8'h00);
    chk("midbus_rst_rsp", {rsp_valid, rsp_err, rsp_rdat, wb_adr, wb_wdat}, '0);
    chk("midbus_rst_ready", cmd_ready, 1'b1);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_rsp_after_rst", {rsp_valid, wb_cyc}, 2'b00);
    end

    // 6: 16 back-to-back random transactions
    for (int t = 0; t < 16; t++) begin
      int d;
      d      = int'($urandom_range(0, 6));
      r_we   = 1'($urandom_range(0, 1));
      r_addr = 17'($urandom_range(0, 15));
      issue(r_we, r_addr, 4'($urandom_range(0, 15)), $urandom, d, 1'b0, d + 1);
      consume(int'($urandom_range(0, 3)));
    end
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 16; i++) chk("mem_final", resp_mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
